systolic_result_drain: RTL and testbench

Consumer-side companion to the 32-lane systolic array. It waits for the array's `ready` flag and snapshots the 32 result words `P[0:31]`. It then pulses a restart request back to the array and streams the first `matrix_N` results out one word per beat over a valid/ready handshake. The block sits between the array outputs and the downstream result store or bus adapter.

---
 rtl/systolic_result_drain_if.sv | 32 +++
 rtl/systolic_result_drain.sv | 108 ++++++++++
 tb/tb_systolic_result_drain.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_result_drain_if.sv
// Result stream interface between the systolic result drain and the
// downstream result store.
//   m_data  : result word of the current beat
//   m_valid : beat is presented
//   m_ready : downstream accepts the beat
//   m_last  : current beat is the final lane of the stream
//   m_index : lane index of the current beat
interface systolic_result_drain_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic [4:0]        m_index;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    output m_index,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    input  m_index,
    output m_ready
  );
endinterface

// File: rtl/systolic_result_drain.sv
// Consumer-side drain for the systolic array. On a rising edge of arr_ready
// it snapshots all lanes of arr_P, pulses arr_clear for one cycle, then
// streams the first min(matrix_N, LANES) words over a valid/ready handshake
// and pulses done after the last beat is accepted.
//   clk, reset : clock, synchronous active-high reset
//   matrix_N   : number of valid lanes, sampled at capture
//   arr_ready  : array result-valid flag (rising edge triggers a capture)
//   arr_P      : array result words [0:LANES-1]
//   arr_clear  : one-cycle restart request to the array
//   m          : result stream (master side)
//   busy       : high whenever not IDLE
//   done       : one-cycle pulse after the final beat is accepted
module systolic_result_drain #(
  parameter int DATA_W = 16,
  parameter int LANES  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        matrix_N,
  input  logic              arr_ready,
  input  logic [DATA_W-1:0] arr_P [0:LANES-1],
  output logic              arr_clear,
  systolic_result_drain_if.master m,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [5:0] LANES_W = 6'(LANES);

  logic [1:0]        state;
  logic [4:0]        idx;
  logic [5:0]        n_eff;
  logic              rdy_q;
  logic [DATA_W-1:0] buf_q [0:LANES-1];

  logic              cap_evt;
  logic [5:0]        n_next;
  logic              is_last;

  // Edges seen outside IDLE are dropped, not queued.
  assign cap_evt = arr_ready && !rdy_q && (state == ST_IDLE);
  assign n_next  = (matrix_N > LANES_W) ? LANES_W : matrix_N;
  assign is_last = ({1'b0, idx} == (n_eff - 6'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      n_eff     <= '0;
      rdy_q     <= 1'b0;
      arr_clear <= 1'b0;
    end else begin
      rdy_q     <= arr_ready;
      arr_clear <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cap_evt) begin
            n_eff     <= n_next;
            idx       <= '0;
            arr_clear <= 1'b1;
            state     <= (n_next == 6'd0) ? ST_DONE : ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (m.m_ready) begin
            if (is_last) begin
              state <= ST_DONE;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Snapshot buffer carries no reset; its contents only matter after a capture.
  always_ff @(posedge clk) begin
    if (!reset && cap_evt) begin
      buf_q <= arr_P;
    end
  end

  always_comb begin
    m.m_valid = (state == ST_STREAM);
    m.m_data  = '0;
    m.m_index = '0;
    m.m_last  = 1'b0;
    if (state == ST_STREAM) begin
      m.m_data  = buf_q[idx];
      m.m_index = idx;
      m.m_last  = is_last;
    end
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
module tb_systolic_result_drain;

  localparam int DW = 16;
  localparam int LN = 32;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [4:0]    i;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    matrix_N;
  logic          arr_ready;
  logic [DW-1:0] arr_P [0:LN-1];
  logic          arr_clear;
  logic          busy;
  logic          done;

  systolic_result_drain_if #(.DATA_W(DW)) m_if ();

  systolic_result_drain #(.DATA_W(DW), .LANES(LN)) dut (
    .clk       (clk),
    .reset     (reset),
    .matrix_N  (matrix_N),
    .arr_ready (arr_ready),
    .arr_P     (arr_P),
    .arr_clear (arr_clear),
    .m         (m_if.master),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int beat_count = 0;
  int clear_count = 0;
  int done_count = 0;
  beat_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: pops one expected beat per accepted handshake and
  // verifies that a stalled beat holds stable into the next cycle.
  logic          stall_q = 1'b0;
  logic [DW-1:0] prev_d;
  logic [4:0]    prev_i;
  logic          prev_l;

  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", 32'(m_if.m_valid), 32'd1);
        check("hold_data",  32'(m_if.m_data),  32'(prev_d));
        check("hold_index", 32'(m_if.m_index), 32'(prev_i));
        check("hold_last",  32'(m_if.m_last),  32'(prev_l));
      end
      if (m_if.m_valid && m_if.m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h index %0d expected no beat",
                   m_if.m_data, m_if.m_index);
        end else begin
          e = exp_q.pop_front();
          check("beat_data",  32'(m_if.m_data),  32'(e.d));
          check("beat_index", 32'(m_if.m_index), 32'(e.i));
          check("beat_last",  32'(m_if.m_last),  32'(e.l));
          beat_count++;
        end
      end
      stall_q = m_if.m_valid && !m_if.m_ready;
      prev_d  = m_if.m_data;
      prev_i  = m_if.m_index;
      prev_l  = m_if.m_last;
      if (arr_clear) clear_count++;
      if (done) done_count++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input int i, input bit l);
    beat_t b;
    b.d = d;
    b.i = 5'(i);
    b.l = l;
    exp_q.push_back(b);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_arr_clear"}, 32'(arr_clear),     32'd0);
    check({name, "_m_valid"},   32'(m_if.m_valid),  32'd0);
    check({name, "_m_last"},    32'(m_if.m_last),   32'd0);
    check({name, "_m_index"},   32'(m_if.m_index),  32'd0);
    check({name, "_m_data"},    32'(m_if.m_data),   32'd0);
    check({name, "_busy"},      32'(busy),          32'd0);
    check({name, "_done"},      32'(done),          32'd0);
  endtask

  // Raises arr_ready (which must have been low the previous cycle), then runs
  // one capture/stream/done sequence. pat[c-1] is m_ready in beat cycle c for
  // c <= plen, 1 afterwards.
  task automatic run(input string name, input int nexp, input logic [15:0] pat,
                     input int plen, input int exp_lat, input bit keep, input bit scramble);
    int lat;
    int c0;
    int d0;
    int b0;
    c0 = clear_count;
    d0 = done_count;
    b0 = beat_count;
    arr_ready = 1'b1;
    m_if.m_ready = 1'b1;
    step();
    lat = 1;
    if (!keep) arr_ready = 1'b0;
    if (scramble) begin
      for (int i = 0; i < LN; i++) arr_P[i] = 16'hFFFF;
    end
    m_if.m_ready = (plen >= 1) ? pat[0] : 1'b1;
    check({name, "_busy_k1"},    32'(busy),         32'd1);
    check({name, "_clear_k1"},   32'(arr_clear),    32'd1);
    check({name, "_valid_k1"},   32'(m_if.m_valid), (nexp > 0) ? 32'd1 : 32'd0);
    while (!done && lat < 300) begin
      step();
      lat++;
      m_if.m_ready = (lat <= plen) ? pat[lat-1] : 1'b1;
    end
    check({name, "_done_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_queue_empty"},  32'(exp_q.size()), 32'd0);
    check({name, "_beats"},        32'(beat_count - b0), 32'(nexp));
    step();
    check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    check({name, "_idle_busy"},      32'(busy), 32'd0);
    check({name, "_clear_pulses"},   32'(clear_count - c0), 32'd1);
    check({name, "_done_pulses"},    32'(done_count - d0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    int d0;
    int b0;
    reset = 1'b1;
    arr_ready = 1'b0;
    matrix_N = '0;
    m_if.m_ready = 1'b0;
    for (int i = 0; i < LN; i++) arr_P[i] = '0;
    repeat (3) step();
    check_idle_outputs("reset");
    reset = 1'b0;
    m_if.m_ready = 1'b1;
    step();

    // Basic stream
    matrix_N = 6'd4;
    for (int i = 0; i < LN; i++) arr_P[i] = 16'h1000 + 16'(i);
    for (int i = 0; i < 4; i++) push_beat(16'h1000 + 16'(i), i, i == 3);
    run("basic", 4, 16'h0, 0, 5, 1'b0, 1'b0);

    // Backpressure: m_ready 1,0,0,1,0,1
    matrix_N = 6'd3;
    for (int i = 0; i < LN; i++) arr_P[i] = 16'h3000 + 16'(i);
    for (int i = 0; i < 3; i++) push_beat(16'h3000 + 16'(i), i, i == 2);
    run("bp", 3, 16'b101001, 6, 7, 1'b0, 1'b0);

    // Zero count
    matrix_N = 6'd0;
    run("zero", 0, 16'h0, 0, 1, 1'b0, 1'b0);

    // Clamp 40 -> 32
    matrix_N = 6'd40;
    for (int i = 0; i < LN; i++) arr_P[i] = 16'(i);
    for (int i = 0; i < 32; i++) push_beat(16'(i), i, i == 31);
    run("clamp", 32, 16'h0, 0, 33, 1'b0, 1'b0);

    // Level hold: arr_ready stays high ~100 cycles
    matrix_N = 6'd2;
    for (int i = 0; i < LN; i++) arr_P[i] = 16'h4000 + 16'(i);
    for (int i = 0; i < 2; i++) push_beat(16'h4000 + 16'(i), i, i == 1);
    c0 = clear_count;
    d0 = done_count;
    b0 = beat_count;
    run("hold", 2, 16'h0, 0, 3, 1'b1, 1'b0);
    repeat (96) step();
    check("hold_total_beats",  32'(beat_count - b0),  32'd2);
    check("hold_total_dones",  32'(done_count - d0),  32'd1);
    check("hold_total_clears", 32'(clear_count - c0), 32'd1);
    check("hold_still_idle",   32'(busy),             32'd0);
    arr_ready = 1'b0;
    step();
    for (int i = 0; i < LN; i++) arr_P[i] = 16'h4100 + 16'(i);
    for (int i = 0; i < 2; i++) push_beat(16'h4100 + 16'(i), i, i == 1);
    run("rehold", 2, 16'h0, 0, 3, 1'b0, 1'b0);

    // Buffer isolation: arr_P overwritten right after capture
    matrix_N = 6'd5;
    for (int i = 0; i < LN; i++) arr_P[i] = 16'hA500 + 16'(i);
    for (int i = 0; i < 5; i++) push_beat(16'hA500 + 16'(i), i, i == 4);
    run("iso", 5, 16'h0, 0, 6, 1'b0, 1'b1);

    // Mid-stream reset while lane 3 pending
    matrix_N = 6'd8;
    for (int i = 0; i < LN; i++) arr_P[i] = 16'h2000 + 16'(i);
    for (int i = 0; i < 8; i++) push_beat(16'h2000 + 16'(i), i, i == 7);
    d0 = done_count;
    arr_ready = 1'b1;
    m_if.m_ready = 1'b1;
    step();
    arr_ready = 1'b0;
    repeat (3) step();
    check("mr_pending_index", 32'(m_if.m_index), 32'd3);
    check("mr_pending_valid", 32'(m_if.m_valid), 32'd1);
    m_if.m_ready = 1'b0;
    reset = 1'b1;
    step();
    check_idle_outputs("mr_after_reset");
    check("mr_unsent", 32'(exp_q.size()), 32'd5);
    exp_q.delete();
    reset = 1'b0;
    m_if.m_ready = 1'b1;
    repeat (4) step();
    check("mr_no_done", 32'(done_count - d0), 32'd0);
    check("mr_idle",    32'(busy),            32'd0);
    matrix_N = 6'd2;
    for (int i = 0; i < LN; i++) arr_P[i] = 16'h5000 + 16'(i);
    for (int i = 0; i < 2; i++) push_beat(16'h5000 + 16'(i), i, i == 1);
    run("restart", 2, 16'h0, 0, 3, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
